// File: rtl/alu_shift_issue.sv
// Two-stage issue/retire wrapper around the external 64-bit shift units.
// S1 registers the operation and drives the shifters; S2 captures the
// selected result behind its own valid/ready handshake.
module alu_shift_issue #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16,
    localparam int SH_W = $clog2(XLEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_A,
    input  logic [XLEN-1:0]  in_B,
    input  logic [1:0]       in_op,
    output logic [XLEN-1:0]  sh_A,
    output logic [SH_W-1:0]  sh_shamt,
    input  logic [XLEN-1:0]  sll_Result,
    input  logic [XLEN-1:0]  srl_Result,
    input  logic [XLEN-1:0]  sra_Result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic             out_zero,
    output logic             out_err,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [SH_W-1:0] shamt;
        op_e             op;
    } s1_req_t;

    s1_req_t         s1;
    logic            s1_valid;
    logic            s2_valid;
    logic            s2_free;
    logic            s1_adv;
    logic            accept;
    logic [XLEN-1:0] mux_res;
    logic            mux_err;

    // Upper shift-amount bits carry no meaning for a 6-bit shamt.
    logic unused_b_hi;
    assign unused_b_hi = ^in_B[XLEN-1:SH_W];

    assign s2_free   = !s2_valid || out_ready;
    assign s1_adv    = s1_valid && s2_free;
    assign in_ready  = rst_n && (!s1_valid || s2_free);
    assign accept    = in_valid && in_ready;
    assign sh_A      = s1.a;
    assign sh_shamt  = s1.shamt;
    assign out_valid = s2_valid;

    // Pick the shifter result for the op held in S1; reserved op yields 0 + error.
    always_comb begin
        mux_res = '0;
        mux_err = 1'b0;
        unique case (s1.op)
            OP_SLL: mux_res = sll_Result;
            OP_SRL: mux_res = srl_Result;
            OP_SRA: mux_res = sra_Result;
            OP_RSV: mux_err = 1'b1;
        endcase
    end

    // S1: load on accept, otherwise drain into S2 when it advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= '0;
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1.a     <= in_A;
            s1.shamt <= in_B[SH_W-1:0];
            s1.op    <= op_e'(in_op);
            s1_valid <= 1'b1;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // S2: capture result on advance; payload holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_zero <= 1'b0;
            out_err  <= 1'b0;
            s2_valid <= 1'b0;
        end else if (s1_adv) begin
            out_data <= mux_res;
            out_zero <= (mux_res == '0);
            out_err  <= mux_err;
            s2_valid <= 1'b1;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    // Count retired operations; wraps naturally at the counter width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            op_count <= '0;
        else if (s2_valid && out_ready)
            op_count <= op_count + 1'b1;
    end

endmodule

// File: tb/tb_alu_shift_issue.sv
// Directed bench for alu_shift_issue: vector table plus hand-written
// back-to-back, backpressure and mid-flight reset sequences.
module tb_alu_shift_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_A, in_B;
    logic [1:0]  in_op;
    logic [63:0] sh_A;
    logic [5:0]  sh_shamt;
    logic [63:0] sll_Result, srl_Result, sra_Result;
    logic        out_valid, out_ready;
    logic [63:0] out_data;
    logic        out_zero, out_err;
    logic [15:0] op_count;

    int          n_pass = 0;
    int          n_total = 0;
    int          exp_cnt = 0;

    always #5 clk = ~clk;

    // Stand-ins for the external combinational shift units.
    assign sll_Result = sh_A << sh_shamt;
    assign srl_Result = sh_A >> sh_shamt;
    assign sra_Result = $signed(sh_A) >>> sh_shamt;

    alu_shift_issue #(.XLEN(64), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_A(in_A), .in_B(in_B), .in_op(in_op),
        .sh_A(sh_A), .sh_shamt(sh_shamt),
        .sll_Result(sll_Result), .srl_Result(srl_Result), .sra_Result(sra_Result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_zero(out_zero), .out_err(out_err),
        .op_count(op_count)
    );

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  op;
        logic [63:0] exp_data;
        logic        exp_zero;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic offer(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
        in_valid = 1'b1; in_A = a; in_B = b; in_op = op;
    endtask

    task automatic run_vec(input vec_t v);
        logic [63:0] b;
        b = v.b;
        @(negedge clk);
        offer(v.a, v.b, v.op);
        out_ready = 1'b1;
        chk({v.name, " in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({v.name, " sh_A"}, sh_A, v.a);
        chk({v.name, " sh_shamt"}, 64'(sh_shamt), 64'(b[5:0]));
        chk({v.name, " early valid"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({v.name, " out_valid"}, 64'(out_valid), 64'd1);
        chk({v.name, " out_data"}, out_data, v.exp_data);
        chk({v.name, " out_zero"}, 64'(out_zero), 64'(v.exp_zero));
        chk({v.name, " out_err"}, 64'(out_err), 64'(v.exp_err));
        exp_cnt++;
        @(negedge clk);
        chk({v.name, " drained"}, 64'(out_valid), 64'd0);
        chk({v.name, " op_count"}, 64'(op_count), 64'(exp_cnt));
    endtask

    initial begin
        vecs[0] = '{"sra8",   64'h8000000000000000, 64'd8,    2'b10, 64'hFF80000000000000, 1'b0, 1'b0};
        vecs[1] = '{"srl_msk",64'h8000000000000000, 64'h48,   2'b01, 64'h0080000000000000, 1'b0, 1'b0};
        vecs[2] = '{"sll63",  64'h1,                64'd63,   2'b00, 64'h8000000000000000, 1'b0, 1'b0};
        vecs[3] = '{"rsv",    64'h5,                64'd0,    2'b11, 64'h0,                1'b1, 1'b1};
        vecs[4] = '{"sra_z",  64'h0,                64'd5,    2'b10, 64'h0,                1'b1, 1'b0};
        vecs[5] = '{"shamt0", 64'h0123456789ABCDEF, 64'h40,   2'b01, 64'h0123456789ABCDEF, 1'b0, 1'b0};
        vecs[6] = '{"sll4",   64'hFFFFFFFFFFFFFFFF, 64'd4,    2'b00, 64'hFFFFFFFFFFFFFFF0, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_A = '0; in_B = '0; in_op = '0; out_ready = 1'b0;
        #1;
        chk("rst in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(negedge clk);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_data", out_data, 64'd0);
        chk("rst sh_A", sh_A, 64'd0);
        chk("rst sh_shamt", 64'(sh_shamt), 64'd0);
        chk("rst flags", {62'd0, out_zero, out_err}, 64'd0);
        chk("rst op_count", 64'(op_count), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post-rst in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Back-to-back SRAs with out_ready held high.
        @(negedge clk);
        out_ready = 1'b1;
        offer(64'hF000000000000000, 64'd32, 2'b10);
        @(negedge clk);
        chk("b2b in_ready", 64'(in_ready), 64'd1);
        offer(64'h8000000000000000, 64'd63, 2'b10);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b r1 valid", 64'(out_valid), 64'd1);
        chk("b2b r1 data", out_data, 64'hFFFFFFFFF0000000);
        @(negedge clk);
        chk("b2b r2 valid", 64'(out_valid), 64'd1);
        chk("b2b r2 data", out_data, 64'hFFFFFFFFFFFFFFFF);
        exp_cnt += 2;
        @(negedge clk);
        chk("b2b drained", 64'(out_valid), 64'd0);
        chk("b2b op_count", 64'(op_count), 64'(exp_cnt));

        // Backpressure: two buffered, third stalls until out_ready rises.
        out_ready = 1'b0;
        offer(64'h1, 64'd1, 2'b00);
        @(negedge clk);
        offer(64'h100, 64'd4, 2'b01);
        chk("bp 2nd in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        offer(64'h40, 64'd3, 2'b10);
        chk("bp full in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("bp still full", 64'(in_ready), 64'd0);
        chk("bp hold valid", 64'(out_valid), 64'd1);
        chk("bp hold data", out_data, 64'h2);
        chk("bp op_count", 64'(op_count), 64'(exp_cnt));
        @(negedge clk);
        chk("bp hold data2", out_data, 64'h2);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp r2 data", out_data, 64'h10);
        @(negedge clk);
        chk("bp r3 valid", 64'(out_valid), 64'd1);
        chk("bp r3 data", out_data, 64'h8);
        exp_cnt += 3;
        @(negedge clk);
        chk("bp drained", 64'(out_valid), 64'd0);
        chk("bp op_count end", 64'(op_count), 64'(exp_cnt));

        // Reset with both stages occupied.
        out_ready = 1'b0;
        offer(64'h3, 64'd1, 2'b00);
        @(negedge clk);
        offer(64'h7, 64'd2, 2'b01);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid pre valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst valid", 64'(out_valid), 64'd0);
        chk("mid rst op_count", 64'(op_count), 64'd0);
        chk("mid rst in_ready", 64'(in_ready), 64'd0);
        chk("mid rst data", out_data, 64'd0);
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("mid rel in_ready", 64'(in_ready), 64'd1);
        repeat (2) begin
            @(negedge clk);
            chk("mid no stale", 64'(out_valid), 64'd0);
        end
        chk("mid op_count", 64'(op_count), 64'(exp_cnt));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
